addsub_serial: RTL and testbench



---
 rtl/addsub_pkg.sv | 17 +
 rtl/addsub_serial_if.sv | 30 +++
 rtl/addsub_digit.sv | 30 +++
 rtl/addsub_serial.sv | 138 +++++++++++++
 tb/tb_addsub_serial.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared types and parameter checks for the digit-serial adder/subtractor.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal when the operand splits into a whole number of non-empty digits.
  function automatic bit digit_ok(int width, int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for addsub_serial.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Ports (master = requester, slave = adder):
//   in_valid, a, b, sub, out_ready : master -> slave
//   in_ready, out_valid, s, c0, ovf : slave -> master
interface addsub_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c0;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, c0, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, c0, ovf
  );
endinterface

// File: rtl/addsub_digit.sv
// DIGIT-bit combinational ripple-carry adder slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: x, y (digit operands), ci (carry in) -> sum, co (carry out), c_msb (carry into digit MSB).
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  always_comb begin
    logic c;
    c     = ci;
    sum   = '0;
    c_msb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      // Carry entering this bit; the last iteration leaves the carry into the MSB.
      c_msb  = c;
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract: DIGIT bits per cycle, LSB digit first, with carry-out and overflow.
// Latency: out_valid rises WIDTH/DIGIT edges after the accepting edge.
// Backpressure: one op in flight; in_ready low from accept until the result handshake completes.
// Ports: clk, rst_n (async active-low), io (slave side of addsub_serial_if).
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  addsub_serial_if.slave  io
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("addsub_serial: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // holds b already inverted for subtract
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_co;
  logic             dig_cmsb;
  logic [WIDTH-1:0] res_next;
  logic             last_dig;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .sum   (dig_sum),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the MSB end so that after NDIG shifts the result is aligned.
  if (DIGIT == WIDTH) begin : g_res_one
    assign res_next = dig_sum;
  end else begin : g_res_many
    assign res_next = {dig_sum, res_q[WIDTH-1:DIGIT]};
  end

  assign last_dig = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          // Subtract is a + ~b + 1: invert b here and feed sub as the first carry.
          a_d        = io.a;
          b_d        = io.b ^ {WIDTH{io.sub}};
          carry_d    = io.sub;
          cnt_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_next;
        carry_d = dig_co;
        cnt_d   = cnt_q + CW'(1);
        if (last_dig) begin
          ovf_d       = dig_co ^ dig_cmsb;
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // After the final digit the carry register holds the carry out of the MSB.
  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.s         = res_q;
  assign io.c0        = carry_q;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three instances (16/4, 8/8, 8/1) against an arithmetic reference.
// Latency: checks exact result latency per instance.
// Backpressure: exercises held results under out_ready=0 and reset abort.
module tb_addsub_serial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wid [3] = '{16, 8, 8};
  int nd  [3] = '{4, 1, 8};

  addsub_serial_if #(.WIDTH(16)) if0 ();
  addsub_serial_if #(.WIDTH(8))  if1 ();
  addsub_serial_if #(.WIDTH(8))  if2 ();

  addsub_serial #(.WIDTH(16), .DIGIT(4)) u0 (.clk(clk), .rst_n(rst_n), .io(if0));
  addsub_serial #(.WIDTH(8),  .DIGIT(8)) u1 (.clk(clk), .rst_n(rst_n), .io(if1));
  addsub_serial #(.WIDTH(8),  .DIGIT(1)) u2 (.clk(clk), .rst_n(rst_n), .io(if2));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(int d, bit v, logic [15:0] a, logic [15:0] b, bit sb);
    case (d)
      0: begin if0.in_valid = v; if0.a = a;      if0.b = b;      if0.sub = sb; end
      1: begin if1.in_valid = v; if1.a = a[7:0]; if1.b = b[7:0]; if1.sub = sb; end
      default: begin if2.in_valid = v; if2.a = a[7:0]; if2.b = b[7:0]; if2.sub = sb; end
    endcase
  endtask

  task automatic set_ordy(int d, bit r);
    case (d)
      0: if0.out_ready = r;
      1: if1.out_ready = r;
      default: if2.out_ready = r;
    endcase
  endtask

  // {in_ready, out_valid, c0, ovf, s[15:0]}
  function automatic logic [19:0] get_out(int d);
    case (d)
      0: return {if0.in_ready, if0.out_valid, if0.c0, if0.ovf, if0.s};
      1: return {if1.in_ready, if1.out_valid, if1.c0, if1.ovf, 8'h00, if1.s};
      default: return {if2.in_ready, if2.out_valid, if2.c0, if2.ovf, 8'h00, if2.s};
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(int w, logic [15:0] a, logic [15:0] b, bit sb,
                       output logic [15:0] s, output bit c0, output bit ov);
    longint m, ua, ub, sa, sbv, r, u;
    m   = longint'(1) << w;
    ua  = longint'(a) % m;
    ub  = longint'(b) % m;
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    r   = sb ? sa - sbv : sa + sbv;
    ov  = (r < -(m / 2)) || (r >= m / 2);
    u   = sb ? ua - ub + m : ua + ub;
    c0  = sb ? (ua >= ub) : (u >= m);
    s   = 16'(u % m);
  endtask

  task automatic chk_idle_reset(int d, string tag);
    logic [19:0] o;
    o = get_out(d);
    chk({tag, "_in_ready"},  o[19],   1);
    chk({tag, "_out_valid"}, o[18],   0);
    chk({tag, "_c0"},        o[17],   0);
    chk({tag, "_ovf"},       o[16],   0);
    chk({tag, "_s"},         o[15:0], 0);
  endtask

  task automatic start(int d, logic [15:0] a, logic [15:0] b, bit sb, string tag);
    logic [19:0] o;
    @(negedge clk);
    o = get_out(d);
    chk({tag, "_ready_pre"}, o[19], 1);
    set_in(d, 1'b1, a, b, sb);
    @(posedge clk);
    #1;
    // Scramble operands while running: they must be ignored.
    set_in(d, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic finish(int d, logic [15:0] a, logic [15:0] b, bit sb, string tag, bit hs);
    logic [15:0] es;
    bit ec, eo, busy_ok;
    logic [19:0] o;
    int lat;
    model(wid[d], a, b, sb, es, ec, eo);
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      o = get_out(d);
      if (o[19] !== 1'b0) busy_ok = 1'b0;
    end while (o[18] !== 1'b1 && lat < 64);
    chk({tag, "_latency"}, lat, nd[d]);
    chk({tag, "_busy"},    busy_ok, 1);
    chk({tag, "_s"},       o[15:0], es);
    chk({tag, "_c0"},      o[17], ec);
    chk({tag, "_ovf"},     o[16], eo);
    if (hs) begin
      set_ordy(d, 1'b1);
      @(posedge clk);
      #1;
      set_ordy(d, 1'b0);
      o = get_out(d);
      chk({tag, "_valid_drop"}, o[18], 0);
      chk({tag, "_ready_back"}, o[19], 1);
    end
  endtask

  task automatic op(int d, logic [15:0] a, logic [15:0] b, bit sb, string tag);
    start(d, a, b, sb, tag);
    finish(d, a, b, sb, tag, 1'b1);
  endtask

  initial begin
    logic [19:0] o;
    logic [15:0] es;
    bit ec, eo;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      set_in(d, 1'b0, 16'h0, 16'h0, 1'b0);
      set_ordy(d, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk_idle_reset(0, "rst0");
    chk_idle_reset(1, "rst1");
    chk_idle_reset(2, "rst2");
    @(negedge clk);
    rst_n = 1'b1;

    op(0, 16'h0000, 16'h0000, 1'b0, "t1_zero");
    op(0, 16'hFFFF, 16'h0001, 1'b0, "t2_wrap");
    op(0, 16'h7FFF, 16'h0001, 1'b0, "t2_ovf");
    op(0, 16'h000A, 16'h0005, 1'b1, "t3_sub_pos");
    op(0, 16'h0005, 16'h000A, 1'b1, "t3_sub_neg");
    op(0, 16'h8000, 16'h0001, 1'b1, "t3_sub_ovf");

    // Backpressure: result must hold while new operands are offered.
    start(0, 16'h1111, 16'h2222, 1'b0, "t4a");
    finish(0, 16'h1111, 16'h2222, 1'b0, "t4a", 1'b0);
    model(16, 16'h1111, 16'h2222, 1'b0, es, ec, eo);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_in(0, 1'b1, 16'h0F0F, 16'h0101, 1'b1);
      @(posedge clk);
      #1;
      o = get_out(0);
      chk("t4_hold_valid", o[18],   1);
      chk("t4_hold_s",     o[15:0], es);
      chk("t4_hold_c0",    o[17],   ec);
      chk("t4_hold_ovf",   o[16],   eo);
      chk("t4_hold_ready", o[19],   0);
    end
    @(negedge clk);
    set_ordy(0, 1'b1);
    @(posedge clk);
    #1;
    set_ordy(0, 1'b0);
    o = get_out(0);
    chk("t4_drain_valid", o[18], 0);
    chk("t4_drain_ready", o[19], 1);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    finish(0, 16'h0F0F, 16'h0101, 1'b1, "t4b", 1'b1);

    // Reset abort on the second RUN cycle.
    start(0, 16'h1234, 16'h1111, 1'b0, "t5a");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    o = get_out(0);
    chk("t5_async_valid", o[18],   0);
    chk("t5_async_s",     o[15:0], 0);
    chk("t5_async_ready", o[19],   1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    o = get_out(0);
    chk("t5_rel_valid", o[18],   0);
    chk("t5_rel_s",     o[15:0], 0);
    chk("t5_rel_ready", o[19],   1);
    op(0, 16'h1234, 16'h1111, 1'b0, "t5b");

    op(1, 16'h00A5, 16'h005A, 1'b0, "t6_w8d8");
    op(2, 16'h0080, 16'h0001, 1'b1, "t6_w8d1");

    for (int i = 0; i < 20; i++) begin
      for (int d = 0; d < 3; d++) begin
        op(d, 16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rnd%0d_d%0d", i, d));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
